// File: rtl/wb_burst_reader.sv
// wb_burst_reader: Wishbone classic burst reader feeding a FWFT FIFO
module wb_burst_reader #(
  parameter int ADR_W = 32,
  parameter int LEN_W = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [3:0]       wb_sel,
  output logic [ADR_W-1:0] wb_adr,
  input  logic [31:0]      wb_dat_sm,
  input  logic             wb_ack,
  input  logic             wb_err,
  input  logic             wb_rty,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, HOLD, FINISH} state_t;
  state_t state, state_nx;
  logic [ADR_W-1:0] adr;
  logic [LEN_W-1:0] rem;
  logic err_q;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic push, pop, room, full_nx;
  assign push = state == READ && wb_ack;
  assign pop = cnt != '0 && out_ready;
  assign cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign room = cnt < (AW+1)'(FIFO_DEPTH);
  assign full_nx = cnt_nx == (AW+1)'(FIFO_DEPTH);
  assign wb_cyc = state == READ || state == HOLD;
  assign wb_stb = state == READ;
  assign wb_we = 1'b0;
  assign wb_sel = 4'hF;
  assign wb_adr = adr;
  assign busy = wb_cyc;
  assign done = state == FINISH;
  assign error = err_q;
  assign out_valid = cnt != '0;
  assign out_data = out_valid ? mem[rp] : '0;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: ack beats err/rty; a single HOLD cycle is the retry wait
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = len == '0 ? FINISH : room ? READ : HOLD;
      READ:   if (wb_ack) state_nx = rem == LEN_W'(1) ? FINISH : full_nx ? HOLD : READ;
              else if (wb_err) state_nx = FINISH;
              else if (wb_rty) state_nx = HOLD;
      HOLD:   if (room) state_nx = READ;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // request address, remaining count and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      adr <= '0;
      rem <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      adr <= {base_adr[ADR_W-1:2], 2'b00};
      rem <= len;
      err_q <= 1'b0;
    end else if (push) begin
      adr <= adr + ADR_W'(4);
      rem <= rem - LEN_W'(1);
    end else if (state == READ && wb_err) begin
      err_q <= 1'b1;
    end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt_nx;
    end
  // FIFO storage, gated by ack so it never overflows
  always_ff @(posedge clk)
    if (push) mem[wp] <= wb_dat_sm;
endmodule

// File: tb/tb_wb_burst_reader.sv
// tb_wb_burst_reader: scoreboard bench for wb_burst_reader
module tb_wb_burst_reader;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [31:0] base_adr = 0;
  logic [15:0] len = 0;
  logic busy, done, error, wb_cyc, wb_stb, wb_we, out_valid;
  logic [3:0] wb_sel;
  logic [31:0] wb_adr, wb_dat_sm, out_data;
  logic wb_ack, wb_err, wb_rty, resp;
  int n_chk = 0, n_fail = 0;
  int lat = 1, rty_at = 0, err_at = 0, resp_base = 0;
  int wcnt = 0, n_resp = 0;
  int mc = 0, n_ack = 0, n_stb = 0, n_cyc = 0, rph = 0, k = 0;
  logic [31:0] rty_adr = 0;
  logic [31:0] dq[$], aq[$];

  always #5 clk = ~clk;

  wb_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len),
    .busy(busy), .done(done), .error(error), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_sm(wb_dat_sm),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // slave: word i of memory holds i, ack after lat cycles of strobe
  assign resp = wb_stb && (wcnt == lat - 1);
  assign wb_rty = resp && (n_resp - resp_base + 1 == rty_at);
  assign wb_err = resp && (n_resp - resp_base + 1 == err_at);
  assign wb_ack = resp && !wb_rty && !wb_err;
  assign wb_dat_sm = wb_adr >> 2;
  always @(posedge clk) begin
    wcnt <= (!wb_stb || resp) ? 0 : wcnt + 1;
    if (resp) n_resp <= n_resp + 1;
  end

  // monitor: addresses, FIFO room, output order, retry behaviour
  always @(negedge clk) begin
    if (!rst_n) mc <= 0;
    else begin
      if (wb_stb) n_stb <= n_stb + 1;
      if (wb_cyc) n_cyc <= n_cyc + 1;
      if (wb_ack) begin
        n_ack <= n_ack + 1;
        chk("fifo_room", mc < 16, 1);
        chk("ack_expected", aq.size() != 0, 1);
        if (aq.size() != 0) chk("ack_adr", wb_adr, aq.pop_front());
      end
      if (out_valid && out_ready) begin
        chk("out_expected", dq.size() != 0, 1);
        if (dq.size() != 0) chk("out_data", out_data, dq.pop_front());
      end
      mc <= mc + (wb_ack ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (rph == 0 && wb_rty) begin
        rph <= 1;
        rty_adr <= wb_adr;
      end else if (rph == 1) begin
        chk("rty_gap", wb_stb, 0);
        chk("rty_hold_adr", wb_adr, rty_adr);
        rph <= 2;
      end else if (rph == 2) begin
        chk("rty_resume", wb_stb, 1);
        chk("rty_same_adr", wb_adr, rty_adr);
        rph <= 3;
      end
    end
  end

  task automatic start_req(input logic [31:0] b, input logic [15:0] l, input int nw);
    resp_base = n_resp;
    @(posedge clk); #1;
    start = 1; base_adr = b; len = l;
    for (int i = 0; i < nw; i++) begin
      dq.push_back(((b & ~32'h3) >> 2) + i);
      aq.push_back((b & ~32'h3) + 4 * i);
    end
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    k = 1;
    chk("busy_t1", busy, l != 0);
    chk("cyc_t1", wb_cyc, l != 0);
  endtask

  task automatic wait_done();
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("cyc_at_done", wb_cyc, 0);
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1;
    while ((dq.size() != 0 || out_valid) && g < 400) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_empty", dq.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    int s, a0, g;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1;
    // single-cycle ack, back-to-back
    lat = 1; out_ready = 1;
    s = n_stb;
    start_req(32'h100, 4, 4);
    wait_done();
    chk("t1_done_at", k, 5);
    drain();
    chk("t1_stb_cycles", n_stb - s, 4);
    // two-cycle ack, FIFO fills and stalls
    lat = 2; out_ready = 0;
    a0 = n_ack;
    start_req(32'h0, 20, 20);
    g = 0;
    while (!(wb_cyc && !wb_stb) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("t2_stall", wb_stb, 0);
    @(negedge clk);
    chk("t2_fifo_full", mc, 16);
    chk("t2_acks", n_ack - a0, 16);
    repeat (4) @(negedge clk);
    chk("t2_still_held", wb_stb, 0);
    chk("t2_still_cyc", wb_cyc, 1);
    out_ready = 1;
    wait_done();
    drain();
    chk("t2_total_acks", n_ack - a0, 20);
    // zero length
    lat = 1;
    s = n_cyc;
    start_req(32'h200, 0, 0);
    wait_done();
    chk("t3_done_at", k, 1);
    chk("t3_valid", out_valid, 0);
    @(negedge clk);
    chk("t3_no_cyc", n_cyc - s, 0);
    // retry on third access
    rty_at = 3;
    a0 = n_ack;
    start_req(32'h300, 5, 5);
    wait_done();
    chk("t4_done_at", k, 8);
    drain();
    chk("t4_rty_seen", rph, 3);
    chk("t4_acks", n_ack - a0, 5);
    rty_at = 0;
    // bus error on second access
    err_at = 2; out_ready = 0;
    start_req(32'h400, 8, 1);
    wait_done();
    chk("t5_error", error, 1);
    @(negedge clk);
    chk("t5_one_word", mc, 1);
    chk("t5_valid", out_valid, 1);
    drain();
    chk("t5_sticky", error, 1);
    err_at = 0;
    start_req(32'h500, 2, 2);
    chk("t5_error_cleared", error, 0);
    wait_done();
    drain();
    // asynchronous reset mid-burst
    out_ready = 0;
    start_req(32'h600, 20, 20);
    g = 0;
    while (mc < 6 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("t6_filled", mc >= 6, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("t6_cyc_async", wb_cyc, 0);
    chk("t6_stb_async", wb_stb, 0);
    chk("t6_valid_async", out_valid, 0);
    dq.delete();
    aq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    start_req(32'h700, 3, 3);
    wait_done();
    chk("t6_done_at", k, 4);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
